// File: rtl/mem_pkg.sv
// Shared types and helpers for dual_port_mem and its init controller.
package mem_pkg;

    typedef enum logic {
        INIT,
        READY
    } init_state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Merge helper is sized for the widest supported word; callers cast in and out.
    localparam int MERGE_MAX_W  = 1024;
    localparam int MERGE_MAX_BE = MERGE_MAX_W / 8;

    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0]  old_word,
        input logic [MERGE_MAX_W-1:0]  new_word,
        input logic [MERGE_MAX_BE-1:0] be
    );
        logic [MERGE_MAX_W-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < MERGE_MAX_BE; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_init_ctrl.sv
// Post-reset clear engine: sweeps INIT_VAL through the array, then hands
// the array write port over to the user write path.
module mem_init_ctrl
    import mem_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 1024,
    parameter int               ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int               BE_W     = WIDTH / 8,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              usr_we,
    input  logic [ADDR_W-1:0] usr_addr,
    input  logic [WIDTH-1:0]  usr_wdata,
    input  logic [BE_W-1:0]   usr_wbe,
    output logic              init_busy,
    output logic              arr_we,
    output logic [ADDR_W-1:0] arr_addr,
    output logic [WIDTH-1:0]  arr_wdata,
    output logic [BE_W-1:0]   arr_wbe
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    init_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        init_busy = 1'b0;
        arr_we    = usr_we;
        arr_addr  = usr_addr;
        arr_wdata = usr_wdata;
        arr_wbe   = usr_wbe;
        case (state_q)
            INIT: begin
                init_busy = 1'b1;
                arr_we    = 1'b1;
                arr_addr  = ptr_q;
                arr_wdata = INIT_VAL;
                arr_wbe   = '1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = READY;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            READY: begin
            end
            default: state_d = INIT;
        endcase
    end

endmodule

// File: rtl/dual_port_mem.sv
// Simple-dual-port synchronous RAM with byte enables, registered read,
// selectable read-during-write result and a post-reset clear engine.
module dual_port_mem
    import mem_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 1024,
    parameter int               ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int               BE_W     = WIDTH / 8,
    parameter int               RDW_MODE = RDW_OLD,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [BE_W-1:0]   wbe,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata,
    output logic              rvalid,
    output logic              init_busy,
    output logic              access_err
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    logic              waddr_ok, raddr_ok, wr_acc, rd_acc;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [WIDTH-1:0]  arr_wdata;
    logic [BE_W-1:0]   arr_wbe;
    logic [WIDTH-1:0]  merged_word;

    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             err_q, err_d;

    mem_init_ctrl #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .BE_W     (BE_W),
        .INIT_VAL (INIT_VAL)
    ) u_init (
        .clk       (clk),
        .rst_n     (rst_n),
        .usr_we    (wr_acc),
        .usr_addr  (waddr),
        .usr_wdata (wdata),
        .usr_wbe   (wbe),
        .init_busy (init_busy),
        .arr_we    (arr_we),
        .arr_addr  (arr_addr),
        .arr_wdata (arr_wdata),
        .arr_wbe   (arr_wbe)
    );

    always_comb begin
        waddr_ok = ({1'b0, waddr} < DEPTH_C);
        raddr_ok = ({1'b0, raddr} < DEPTH_C);
        wr_acc   = !init_busy && wen && waddr_ok;
        rd_acc   = !init_busy && ren && raddr_ok;
        err_d    = (init_busy && (wen || ren)) || (wen && !waddr_ok) || (ren && !raddr_ok);

        merged_word = WIDTH'(byte_merge(MERGE_MAX_W'(mem[raddr]), MERGE_MAX_W'(wdata),
                                        MERGE_MAX_BE'(wbe)));

        rvalid_d = rd_acc;
        rdata_d  = rdata_q;
        if (rd_acc) begin
            // New-data mode forwards the merged write word around the array.
            if (RDW_MODE == RDW_NEW && wr_acc && waddr == raddr) begin
                rdata_d = merged_word;
            end else begin
                rdata_d = mem[raddr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (arr_wbe[i]) begin
                    mem[arr_addr][8*i +: 8] <= arr_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign rdata      = rdata_q;
    assign rvalid     = rvalid_q;
    assign access_err = err_q;

endmodule

// File: tb/tb_dual_port_mem.sv
// Scoreboard bench for dual_port_mem: an 8-bit/16-word old-data instance (A)
// and a 32-bit/10-word new-data instance (B) driven side by side.
module tb_dual_port_mem;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        wen_v   [2];
    logic        ren_v   [2];
    logic [3:0]  waddr_v [2];
    logic [3:0]  raddr_v [2];
    logic [31:0] wdata_v [2];
    logic [3:0]  wbe_v   [2];

    logic [7:0]  a_rdata;
    logic        a_rvalid, a_busy, a_err;
    logic [31:0] b_rdata;
    logic        b_rvalid, b_busy, b_err;

    dual_port_mem #(
        .WIDTH    (8),
        .DEPTH    (16),
        .RDW_MODE (0),
        .INIT_VAL (8'h5A)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .wen        (wen_v[0]),
        .waddr      (waddr_v[0]),
        .wdata      (wdata_v[0][7:0]),
        .wbe        (wbe_v[0][0:0]),
        .ren        (ren_v[0]),
        .raddr      (raddr_v[0]),
        .rdata      (a_rdata),
        .rvalid     (a_rvalid),
        .init_busy  (a_busy),
        .access_err (a_err)
    );

    dual_port_mem #(
        .WIDTH    (32),
        .DEPTH    (10),
        .RDW_MODE (1),
        .INIT_VAL (32'h0)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .wen        (wen_v[1]),
        .waddr      (waddr_v[1]),
        .wdata      (wdata_v[1]),
        .wbe        (wbe_v[1]),
        .ren        (ren_v[1]),
        .raddr      (raddr_v[1]),
        .rdata      (b_rdata),
        .rvalid     (b_rvalid),
        .init_busy  (b_busy),
        .access_err (b_err)
    );

    // Reference model state
    int          dep_m   [2] = '{16, 10};
    int          bytes_m [2] = '{1, 4};
    int          rdw_m   [2] = '{0, 1};
    logic [31:0] init_m  [2] = '{32'h5A, 32'h0};
    logic [31:0] mdl     [2][16];
    logic        ready_m [2];
    int          init_cnt[2];
    logic [31:0] last_rd [2];
    logic        exp_rv  [2];
    logic        exp_err [2];
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic string dn(input int d);
        return (d == 0) ? "A" : "B";
    endfunction

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            wen_v[d]   = 1'b0;
            ren_v[d]   = 1'b0;
            waddr_v[d] = '0;
            raddr_v[d] = '0;
            wdata_v[d] = '0;
            wbe_v[d]   = '0;
        end
    endtask

    task automatic set_wr(input int d, input logic [3:0] a, input logic [31:0] data,
                          input logic [3:0] be);
        wen_v[d]   = 1'b1;
        waddr_v[d] = a;
        wdata_v[d] = data;
        wbe_v[d]   = be;
    endtask

    task automatic set_rd(input int d, input logic [3:0] a);
        ren_v[d]   = 1'b1;
        raddr_v[d] = a;
    endtask

    // Predict from the driven inputs, advance one edge, then check every output.
    task automatic tick();
        logic        wok, rok, rv, er, bz;
        logic [31:0] nw, rexp, rd, e;
        int          qn;
        for (int d = 0; d < 2; d++) begin
            wok = ready_m[d] && wen_v[d] && (int'(waddr_v[d]) < dep_m[d]);
            rok = ready_m[d] && ren_v[d] && (int'(raddr_v[d]) < dep_m[d]);
            exp_err[d] = (!ready_m[d] && (wen_v[d] || ren_v[d]))
                       || (wen_v[d] && int'(waddr_v[d]) >= dep_m[d])
                       || (ren_v[d] && int'(raddr_v[d]) >= dep_m[d]);
            exp_rv[d] = rok;
            nw = mdl[d][waddr_v[d]];
            for (int b = 0; b < bytes_m[d]; b++) begin
                if (wbe_v[d][b]) nw[8*b +: 8] = wdata_v[d][8*b +: 8];
            end
            if (rok) begin
                rexp = mdl[d][raddr_v[d]];
                if (wok && waddr_v[d] == raddr_v[d] && rdw_m[d] == 1) rexp = nw;
                if (d == 0) exp_q0.push_back(rexp);
                else        exp_q1.push_back(rexp);
            end
            if (wok) mdl[d][waddr_v[d]] = nw;
            if (!ready_m[d]) begin
                init_cnt[d]++;
                if (init_cnt[d] == dep_m[d]) begin
                    ready_m[d] = 1'b1;
                    for (int a = 0; a < 16; a++) mdl[d][a] = init_m[d];
                end
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            rv = (d == 0) ? a_rvalid : b_rvalid;
            er = (d == 0) ? a_err    : b_err;
            bz = (d == 0) ? a_busy   : b_busy;
            rd = (d == 0) ? {24'h0, a_rdata} : b_rdata;
            check_eq({dn(d), "_rvalid"}, {31'b0, rv}, {31'b0, exp_rv[d]});
            check_eq({dn(d), "_access_err"}, {31'b0, er}, {31'b0, exp_err[d]});
            check_eq({dn(d), "_init_busy"}, {31'b0, bz}, {31'b0, !ready_m[d]});
            if (rv) begin
                qn = (d == 0) ? exp_q0.size() : exp_q1.size();
                if (qn == 0) begin
                    check_eq({dn(d), "_unexpected_rvalid"}, {31'b0, rv}, 32'd0);
                end else begin
                    if (d == 0) e = exp_q0.pop_front();
                    else        e = exp_q1.pop_front();
                    check_eq({dn(d), "_rdata"}, rd, e);
                    last_rd[d] = e;
                end
            end else begin
                check_eq({dn(d), "_rdata_hold"}, rd, last_rd[d]);
            end
        end
    endtask

    // Called at posedge+1; asserts reset between edges and checks outputs clear at once.
    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        check_eq("A_rst_rdata",  {24'h0, a_rdata}, 32'h0);
        check_eq("A_rst_rvalid", {31'b0, a_rvalid}, 32'h0);
        check_eq("A_rst_err",    {31'b0, a_err}, 32'h0);
        check_eq("A_rst_busy",   {31'b0, a_busy}, 32'h1);
        check_eq("B_rst_rdata",  b_rdata, 32'h0);
        check_eq("B_rst_rvalid", {31'b0, b_rvalid}, 32'h0);
        check_eq("B_rst_err",    {31'b0, b_err}, 32'h0);
        check_eq("B_rst_busy",   {31'b0, b_busy}, 32'h1);
        exp_q0.delete();
        exp_q1.delete();
        for (int d = 0; d < 2; d++) begin
            ready_m[d]  = 1'b0;
            init_cnt[d] = 0;
            last_rd[d]  = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int n_rv;

    initial begin
        idle();
        @(posedge clk);
        #1;
        do_reset();

        // Init sweep; requests during init must be dropped and flagged
        for (int c = 0; c < 16; c++) begin
            idle();
            if (c == 2)  set_rd(0, 4'd0);
            if (c == 3)  set_wr(1, 4'd1, 32'hFFFF_FFFF, 4'hF);
            if (c == 15) set_rd(0, 4'd4);
            tick();
        end

        // Every word reads back as INIT_VAL
        for (int a = 0; a < 16; a++) begin
            idle();
            set_rd(0, 4'(a));
            if (a < 10) set_rd(1, 4'(a));
            tick();
        end

        // Streaming writes then back-to-back reads on A
        n_rv = 0;
        idle(); set_wr(0, 4'd1, 32'h8C, 4'h1); tick(); n_rv += int'(a_rvalid);
        idle(); set_wr(0, 4'd2, 32'hA4, 4'h1); tick(); n_rv += int'(a_rvalid);
        idle(); set_wr(0, 4'd3, 32'h2C, 4'h1); tick(); n_rv += int'(a_rvalid);
        for (int a = 1; a <= 3; a++) begin
            idle(); set_rd(0, 4'(a)); tick(); n_rv += int'(a_rvalid);
        end
        idle(); tick(); n_rv += int'(a_rvalid);
        check_eq("A_stream_rvalid_cycles", n_rv, 32'd3);

        // Read-during-write, old-data (A) and new-data (B)
        idle(); set_wr(0, 4'd7, 32'h8C, 4'h1); set_wr(1, 4'd7, 32'h8C, 4'hF); tick();
        idle(); set_wr(0, 4'd7, 32'hA4, 4'h1); set_rd(0, 4'd7);
        set_wr(1, 4'd7, 32'hA4, 4'hF); set_rd(1, 4'd7); tick();
        check_eq("A_rdw_old", {24'h0, a_rdata}, 32'h8C);
        check_eq("B_rdw_new", b_rdata, 32'hA4);
        idle(); set_rd(0, 4'd7); set_wr(1, 4'd7, 32'h0000_FF00, 4'h2); set_rd(1, 4'd7); tick();
        check_eq("A_rdw_after", {24'h0, a_rdata}, 32'hA4);
        check_eq("B_rdw_partial", b_rdata, 32'h0000_FFA4);

        // Byte-enable merge on B
        idle(); set_wr(1, 4'd3, 32'h1122_3344, 4'hF); tick();
        idle(); set_wr(1, 4'd3, 32'hAABB_CCDD, 4'h5); tick();
        idle(); set_wr(1, 4'd4, 32'hDEAD_BEEF, 4'h0); set_rd(1, 4'd3); tick();
        check_eq("B_be_merge", b_rdata, 32'h11BB_33DD);

        // Out-of-range on B: both ports dropped, one-cycle error pulse
        idle(); set_wr(1, 4'd12, 32'hDEAD_BEEF, 4'hF); set_rd(1, 4'd15); tick();
        idle(); set_rd(1, 4'd10); tick();
        idle(); tick();
        for (int a = 0; a < 10; a++) begin
            idle(); set_rd(1, 4'(a)); tick();
        end

        // Reset while a read result is held and another read is pending
        idle(); set_rd(0, 4'd2); set_rd(1, 4'd3); tick();
        idle(); set_rd(0, 4'd1); set_rd(1, 4'd7);
        do_reset();

        // Reset mid-init at pointer 5, then a full init must follow
        for (int c = 0; c < 5; c++) begin
            idle(); tick();
        end
        do_reset();
        for (int c = 0; c < 16; c++) begin
            idle(); tick();
        end
        for (int a = 0; a < 4; a++) begin
            idle(); set_rd(0, 4'(a)); set_rd(1, 4'(a)); tick();
        end
        idle(); tick();

        check_eq("A_sb_drained", exp_q0.size(), 32'd0);
        check_eq("B_sb_drained", exp_q1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
